dm_access_arbiter: RTL
======================

// Module: dm_access_arbiter
// PURPOSE
//  Shares the single-port data memory (DM) between two requesters: port 0 = CPU MEM stage,
//  port 1 = DMA/debug loader. Arbitrates, sequences each access against the DM's fixed read
//  latency, returns the response to the owner, and stalls the pipeline while the CPU waits.
//  Sits between MEM-stage control (MemRead/MemWrite/byte enables) and the DM array.
// PARAMETERS
//  ADDR_W     12    DM word-address width (mem_addr)
//  DM_WORDS   3072  valid words; byte addr >= DM_WORDS*4 is out of range
//  MEM_LAT    2     DM read latency in cycles, 1..4; mem_rdata valid MEM_LAT cycles after mem_req
//  STARVE_MAX 3     consecutive port-0 grants allowed while port 1 waits (1..15)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low (0 = in reset)
//  pN_req      in   1       N=0,1: request; hold until pN_gnt
//  pN_we       in   1       1 = write, 0 = read
//  pN_be       in   4       byte-lane enables
//  pN_addr     in   32      byte address
//  pN_wdata    in   32      write data, lane-aligned
//  pN_gnt      out  1       request accepted (IDLE only), 1-cycle pulse
//  pN_rvalid   out  1       response pulse, 1 cycle, owner only
//  pN_rdata    out  32      read data, valid with pN_rvalid (0 for writes/errors)
//  pN_err      out  1       access rejected, valid with pN_rvalid
//  mem_req     out  1       DM access strobe, 1 cycle
//  mem_we      out  1       DM write enable
//  mem_be      out  4       DM byte enables
//  mem_addr    out  ADDR_W  DM word address = pN_addr[ADDR_W+1:2]
//  mem_wdata   out  32      DM write data
//  mem_rdata   in   32      DM read data
//  cpu_stall   out  1       = p0_req & ~p0_rvalid (combinational)
// BEHAVIOUR
//  - Reset: state IDLE, starve count 0, all registered outputs 0; takes effect immediately.
//    Reset mid-transaction drops it: no rvalid; requester reissues.
//  - FSM IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE; one outstanding access.
//  - IDLE: arbitrate among pN_req; pN_gnt asserted combinationally in this cycle (T); latch
//    owner, we, be, addr, wdata, err. No grant in any other state.
//  - Arbitration: port 0 wins unless p1_req=1 and starve count == STARVE_MAX. Starve count
//    increments on each port-0 grant while p1_req=1 and clears on any port-1 grant or any
//    arbitration with p1_req=0. Saturates at STARVE_MAX.
//  - err = (addr >= DM_WORDS*4) | be not in {0001,0010,0100,1000,0011,1100,1111}.
//  - ISSUE (T+1): if !err, mem_req=1 with latched fields; else no mem_req.
//    Read ok -> WAIT; write or err -> RESP.
//  - WAIT: down-counter loaded MEM_LAT-1; capture mem_rdata at the edge ending the cycle
//    MEM_LAT after ISSUE, then -> RESP.
//  - RESP: owner's rvalid=1 with rdata/err; -> IDLE. Read rvalid at T+2+MEM_LAT; write/err at T+2.
//  - Back-to-back: next grant earliest one cycle after RESP (IDLE). Requester that holds req
//    through RESP is re-arbitrated as a new request.
//  - pN_req dropped before grant: no access. Field changes after grant: ignored.
//  - Outputs mem_* are 0 when mem_req=0.
// STRUCTURE
//  - Shared include dm_arb_defs.v: FSM state encodings (IDLE/ISSUE/WAIT/RESP),
//    port ids, legal-be list.
//  - Sub-module arb_starve_cnt: starvation counter + grant decision (inputs p0_req, p1_req,
//    arbitrate strobe; output winner).
//  - Top: FSM, latch registers, latency counter, response registers.
// TESTING (MEM_LAT=2, STARVE_MAX=3, DM_WORDS=3072)
//  1. p0 read 0x10, DM word 4 = 0xDEADBEEF -> p0_gnt @T, mem_req/mem_addr=4 @T+1,
//     p0_rvalid rdata=0xDEADBEEF err=0 @T+4; cpu_stall=1 T..T+3.
//  2. p0 write 0x8 be=0011 wdata=0x12345678 -> mem_we=1 mem_be=0011 mem_addr=2 @T+1,
//     p0_rvalid err=0 @T+2.
//  3. p0_req and p1_req held high -> grant order p0,p0,p0,p1,p0...; p1 never waits >3 grants.
//  4. p1 read 0x4000 -> no mem_req, p1_rvalid err=1 rdata=0 @T+2; p0 outputs stay 0.
//  5. p0 read be=0110 addr 0x20 -> err=1, no mem_req; then be=1111 same addr succeeds.
//  6. reset=0 during WAIT -> all outputs 0 same cycle, no rvalid after release;
//     next p0 read served as in test 1.

Source files
------------

// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
// Contents: FSM state encoding, requester port ids, and the legal
// byte-enable classifier used when a request is accepted.
package dm_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Only naturally aligned byte, halfword and word lane patterns are accepted.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_arbiter_starve_cnt.sv
// Grant decision with starvation protection for the DMA port.
// Ports: clk/reset (async active-low), p0_req/p1_req requests,
// arbitrate strobe (an arbitration happens this cycle), winner
// (combinational; PORT_CPU or PORT_DMA).
module arb_starve_cnt
  import dm_access_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic p0_req,
  input  logic p1_req,
  input  logic arbitrate,
  output logic winner
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_r;
  logic [3:0] cnt_s;

  // Pick the winner: the CPU has priority until the DMA port has been passed over CNT_MAX times.
  always_comb begin
    winner = PORT_CPU;
    if (p1_req && (cnt_r == CNT_MAX)) begin
      winner = PORT_DMA;
    end else if (p0_req) begin
      winner = PORT_CPU;
    end else if (p1_req) begin
      winner = PORT_DMA;
    end else begin
      winner = PORT_CPU;
    end
  end

  // Next count: grows only while the DMA port is waiting behind a CPU grant, saturating.
  always_comb begin
    cnt_s = cnt_r;
    if (!arbitrate) begin
      cnt_s = cnt_r;
    end else if (winner == PORT_DMA) begin
      cnt_s = 4'd0;
    end else if (p1_req) begin
      cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 4'd1;
    end else begin
      cnt_s = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = CPU MEM stage, port 1 = DMA/debug loader. One access in flight:
// IDLE (grant) -> ISSUE (mem strobe) -> WAIT (read latency) -> RESP -> IDLE.
// Ports: pN_req/we/be/addr/wdata requests, pN_gnt (comb grant pulse),
// pN_rvalid/rdata/err (registered response), mem_* DM interface
// (registered, zero when idle), cpu_stall (comb).
module dm_access_arbiter
  import dm_access_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DM_WORDS   = 3072,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_be,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_be,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall
);

  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);
  localparam logic [1:0]  LAT_LOAD = 2'(MEM_LAT - 1);

  arb_state_e state_r, state_s;
  logic        arbitrate_s, winner_s;
  logic        sel_we_s, sel_err_s;
  logic [3:0]  sel_be_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic        owner_r, we_r, err_r;
  logic [1:0]  lat_cnt_r;
  logic        mem_req_s, mem_we_s;
  logic [3:0]  mem_be_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic        rvalid_s, rerr_s;
  logic [31:0] rdata_s;

  assign arbitrate_s = (state_r == ST_IDLE) && (p0_req || p1_req);
  assign p0_gnt      = arbitrate_s && (winner_s == PORT_CPU);
  assign p1_gnt      = arbitrate_s && (winner_s == PORT_DMA);
  assign cpu_stall   = p0_req && !p0_rvalid;

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .arbitrate (arbitrate_s),
    .winner    (winner_s)
  );

  // Route the winning requester's fields and classify the access as legal or rejected.
  always_comb begin
    if (winner_s == PORT_DMA) begin
      sel_we_s    = p1_we;
      sel_be_s    = p1_be;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_be_s    = p0_be;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
    sel_err_s = (sel_addr_s >= DM_BYTES) || !be_legal(sel_be_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = arbitrate_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_s = (!err_r && !we_r) ? ST_WAIT : ST_RESP;
      ST_WAIT:  state_s = (lat_cnt_r == 2'd0) ? ST_RESP : ST_WAIT;
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: values the output registers take at the end of this cycle.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_be_s    = 4'd0;
    mem_addr_s  = '0;
    mem_wdata_s = 32'd0;
    rvalid_s    = 1'b0;
    rdata_s     = 32'd0;
    rerr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The mem_* registers double as the latched address/data of the access.
        if (arbitrate_s && !sel_err_s) begin
          mem_req_s   = 1'b1;
          mem_we_s    = sel_we_s;
          mem_be_s    = sel_be_s;
          mem_addr_s  = sel_addr_s[ADDR_W+1:2];
          mem_wdata_s = sel_wdata_s;
        end else begin
          mem_req_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (we_r || err_r) begin
          rvalid_s = 1'b1;
          rerr_s   = err_r;
        end else begin
          rvalid_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == 2'd0) begin
          rvalid_s = 1'b1;
          rdata_s  = mem_rdata;
        end else begin
          rvalid_s = 1'b0;
        end
      end
      ST_RESP: rvalid_s = 1'b0;
      default: rvalid_s = 1'b0;
    endcase
  end

  // Latch owner, direction and rejection status of the accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r <= PORT_CPU;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
    end else if (arbitrate_s) begin
      owner_r <= winner_s;
      we_r    <= sel_we_s;
      err_r   <= sel_err_s;
    end
  end

  // Read-latency down-counter: loaded on issue, counts out the remaining WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt_r <= 2'd0;
    end else if (state_r == ST_ISSUE) begin
      lat_cnt_r <= LAT_LOAD;
    end else if ((state_r == ST_WAIT) && (lat_cnt_r != 2'd0)) begin
      lat_cnt_r <= lat_cnt_r - 2'd1;
    end
  end

  // Registered DM strobe and per-port response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      p0_rvalid <= 1'b0;
      p0_rdata  <= 32'd0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= 32'd0;
      p1_err    <= 1'b0;
    end else begin
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_be    <= mem_be_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      p0_rvalid <= rvalid_s && (owner_r == PORT_CPU);
      p0_rdata  <= (rvalid_s && (owner_r == PORT_CPU)) ? rdata_s : 32'd0;
      p0_err    <= rvalid_s && (owner_r == PORT_CPU) && rerr_s;
      p1_rvalid <= rvalid_s && (owner_r == PORT_DMA);
      p1_rdata  <= (rvalid_s && (owner_r == PORT_DMA)) ? rdata_s : 32'd0;
      p1_err    <= rvalid_s && (owner_r == PORT_DMA) && rerr_s;
    end
  end

endmodule
